// File: rtl/tsc_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM state encoding
// and settle counter width.
package tsc_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/truth_sweep_ctrl_settle_timer.sv
// Settle delay counter: loads SETTLE-1 when a vector is driven, counts down
// while the controller waits, and flags zero when the wait is over.
module settle_timer
    import tsc_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam logic [CNT_W-1:0] RELOAD = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

    logic [CNT_W-1:0] r_cnt;

    // Counter register: load has priority over decrement; never underflows.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_sweep_ctrl.sv
// Sweeps an N_IN-input function pair through every input vector, captures both
// truth tables and reports equivalence. Optional macro: TSC_STOP_ON_FAIL_EN.
module truth_sweep_ctrl
    import tsc_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s1_in,
    input  logic                   s2_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   equiv,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   fail_seen,
    output logic [N_IN-1:0]        first_fail,
    output logic [(1<<N_IN)-1:0]   tt1,
    output logic [(1<<N_IN)-1:0]   tt2
);

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic            ZERO_SETTLE = (SETTLE == 0);

    state_t                  r_state;
    state_t                  w_next;
    logic [N_IN-1:0]         r_vec;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_equiv;
    logic [N_IN:0]           r_mm_cnt;
    logic                    r_fail_seen;
    logic [N_IN-1:0]         r_first_fail;
    logic [(1<<N_IN)-1:0]    r_tt1;
    logic [(1<<N_IN)-1:0]    r_tt2;

    logic                    w_mis;
    logic                    w_last;
    logic                    w_stop;
    logic                    w_end;
    logic [N_IN:0]           w_mm_next;
    logic                    w_load;
    logic                    w_zero;

    assign w_mis     = s1_in ^ s2_in;
    assign w_last    = (r_vec == LAST_VEC);
    assign w_mm_next = r_mm_cnt + {{N_IN{1'b0}}, w_mis};

`ifdef TSC_STOP_ON_FAIL_EN
    assign w_stop = w_mis;
`else
    assign w_stop = 1'b0;
`endif

    assign w_end  = w_last | w_stop;
    assign w_load = ((r_state == ST_IDLE) && start) ||
                    ((r_state == ST_SAMPLE) && !w_end);

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_load),
        .i_dec  (r_state == ST_SETTLE),
        .o_zero (w_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ZERO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (w_zero) begin
                    w_next = ST_SAMPLE;
                end else begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (w_end) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ZERO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Result and output registers; equiv is resolved as done rises so both
    // are valid in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_equiv      <= 1'b0;
            r_mm_cnt     <= '0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= '0;
            r_tt1        <= '0;
            r_tt2        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_equiv      <= 1'b0;
                        r_mm_cnt     <= '0;
                        r_fail_seen  <= 1'b0;
                        r_first_fail <= '0;
                        r_tt1        <= '0;
                        r_tt2        <= '0;
                    end
                end
                ST_SAMPLE: begin
                    r_tt1[r_vec] <= s1_in;
                    r_tt2[r_vec] <= s2_in;
                    r_mm_cnt     <= w_mm_next;
                    if (w_mis && !r_fail_seen) begin
                        r_first_fail <= r_vec;
                        r_fail_seen  <= 1'b1;
                    end
                    if (w_end) begin
                        r_done  <= 1'b1;
                        r_equiv <= (w_mm_next == '0);
                    end else begin
                        r_vec <= r_vec + N_IN'(1);
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_vec  <= '0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign vec_out      = r_vec;
    assign busy         = r_busy;
    assign done         = r_done;
    assign equiv        = r_equiv;
    assign mismatch_cnt = r_mm_cnt;
    assign fail_seen    = r_fail_seen;
    assign first_fail   = r_first_fail;
    assign tt1          = r_tt1;
    assign tt2          = r_tt2;

endmodule

// File: doc/truth_sweep_ctrl.md
Name: truth_sweep_ctrl

Overview:
Sequencer that drives an N-input combinational function block through every input vector (0 to 2^N-1). It samples the block's two outputs after a programmable settle delay and checks them for equivalence. It records both captured truth tables, the mismatch count and the first failing vector. It sits between a bench/top-level start strobe and a two-output expression pair such as fxy (s1, s2).

Parameters:
N_IN, 2, number of function inputs; vec_out width; sweep length 2^N_IN (legal 1..6)
SETTLE, 1, wait cycles between driving a vector and sampling (legal 0..15)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
s1_in  input  1  first function output under test
s2_in  input  1  second function output under test
vec_out  output  N_IN  input vector driven to the function block (x = MSB)
busy  output  1  high from first cycle after accepted start until DONE
done  output  1  one-cycle pulse, sweep finished
equiv  output  1  valid when done/idle after sweep: 1 = no mismatches
mismatch_cnt  output  N_IN+1  number of vectors where s1_in != s2_in
fail_seen  output  1  at least one mismatch recorded
first_fail  output  N_IN  lowest vector index that mismatched (0 if none)
tt1  output  2^N_IN  captured s1 truth table, bit k = s1 at vector k
tt2  output  2^N_IN  captured s2 truth table

Behaviour:
- Reset (async, immediate): state IDLE; vec_out, busy, done, equiv, mismatch_cnt, fail_seen, first_fail, tt1, tt2 all 0. Reset mid-sweep aborts; no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE. Settle counter width 4.
- IDLE + start=1: vec_out<=0, clear all result regs, busy<=1, cnt<=SETTLE-1. Next state is SETTLE (SETTLE>0) or SAMPLE (SETTLE==0).
- SETTLE: hold vec_out; if cnt==0 -> SAMPLE, else cnt<=cnt-1. Occupies exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - tt1[vec_out]<=s1_in; tt2[vec_out]<=s2_in.
  - If s1_in!=s2_in: mismatch_cnt++. If fail_seen==0, first_fail<=vec_out and fail_seen<=1.
  - If vec_out==2^N_IN-1 -> DONE. Else vec_out++, reload cnt, -> SETTLE (or SAMPLE if SETTLE==0).
- DONE (1 cycle): done=1, busy<=0, equiv<=(final mismatch_cnt==0), vec_out<=0, -> IDLE.
- Latency: vector k sampled in cycle (k+1)(SETTLE+1) after the start edge. done is high in cycle 2^N_IN(SETTLE+1)+1.
- Results hold in IDLE until the next accepted start.
- start while busy or in DONE: ignored; no restart, no queuing.
- vec_out never wraps past 2^N_IN-1. mismatch_cnt max 2^N_IN fits its width.
- equiv is 0 during a sweep.

Optional Feature:
TSC_STOP_ON_FAIL_EN:
- Defined: a mismatch in SAMPLE goes directly to DONE. tt1/tt2 bits for later vectors stay 0, mismatch_cnt=1, equiv=0.
- Undefined: the full sweep always runs (default).

Decomposition:
- Shared package/include tsc_pkg: state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3) and the SETTLE counter width constant.
- One natural sub-module: settle_timer. Provides load/decrement of cnt and a zero flag.
- FSM and result registers stay in truth_sweep_ctrl.

Test Plan:
- N_IN=2, SETTLE=1, s1=s2=x&y: pulse start -> tt1=tt2=4'b1000, mismatch_cnt=0, equiv=1, fail_seen=0, done high exactly cycle 9 after start edge.
- s1=x&y, s2=x|y: sweep -> tt1=4'b1000, tt2=4'b1110, mismatch_cnt=2, first_fail=2'b01, fail_seen=1, equiv=0.
- SETTLE=0 with same pair: vectors sampled on consecutive cycles 1..4, done at cycle 5, results as above.
- TSC_STOP_ON_FAIL_EN defined, s1=x&y, s2=x|y: done at cycle 5 (vector 1 sampled cycle 4), mismatch_cnt=1, first_fail=01, tt2=4'b0010.
- start re-pulsed at cycle 3 during sweep -> ignored; single done at cycle 9, results unchanged vs scenario 1.
- rst asserted at cycle 5 mid-sweep -> all outputs 0 immediately, no done pulse; new start after release gives a full correct sweep.
